// File: rtl/dm_responder.sv
// Data-memory responder: word RAM plus an MMIO page (LED, cycle counter, status).
// The optional down-counting timer with IRQ is built only when DM_TIMER_EN is defined.
module dm_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LED_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    output logic             irq,
    output logic             err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
    localparam logic [5:0] OFF_TSTAT  = 6'h05;

    logic          is_mmio;
    logic          is_ram;
    logic          misaligned;
    logic          ram_we;
    logic          wr_led;
    logic          wr_tstat;
    logic [5:0]    off;
    logic [AW-1:0] widx;

    logic [31:0]      mem_q [DEPTH];
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q, cycle_d;
    logic             err_q, err_d;
    logic             irq_bit;

    always_comb begin
        is_mmio    = (addr[31:16] == 16'hFFFF);
        is_ram     = !is_mmio && (addr < RAM_BYTES);
        misaligned = (addr[1:0] != 2'b00);
        off        = addr[7:2];
        widx       = addr[AW+1:2];
        // Gating with rst drops a store whose edge lands while reset is held.
        ram_we     = rst && MemWrite && is_ram;
        wr_led     = MemWrite && is_mmio && (off == OFF_LED);
        wr_tstat   = MemWrite && is_mmio && (off == OFF_TSTAT);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[widx] <= wdata;
        end
    end

    always_comb begin
        led_d   = wr_led ? wdata[LED_W-1:0] : led_q;
        cycle_d = cycle_q + 32'd1;
        err_d   = (MemWrite && (misaligned || (!is_mmio && !is_ram)))
                  || (err_q && !(wr_tstat && wdata[1]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            cycle_q <= '0;
            err_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

`ifdef DM_TIMER_EN
    localparam logic [5:0] OFF_TLOAD  = 6'h02;
    localparam logic [5:0] OFF_TCTRL  = 6'h03;
    localparam logic [5:0] OFF_TCOUNT = 6'h04;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tstate_e;

    tstate_e     state_q, state_d;
    logic [31:0] tload_q, tload_d;
    logic [31:0] tcount_q, tcount_d;
    logic [1:0]  tctrl_q, tctrl_d;
    logic        irq_q, irq_d;
    logic        wr_tload;
    logic        wr_tctrl;
    logic        expire;

    always_comb begin
        wr_tload = MemWrite && is_mmio && (off == OFF_TLOAD);
        wr_tctrl = MemWrite && is_mmio && (off == OFF_TCTRL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_tctrl) begin
            state_d = wdata[0] ? T_RUN : T_IDLE;
        end else if (state_q == T_RUN && tcount_q == '0 && !tctrl_q[1]) begin
            state_d = T_DONE;
        end
    end

    // A TCTRL write takes priority over counting/expiry in the same cycle.
    always_comb begin
        tload_d  = wr_tload ? wdata : tload_q;
        tctrl_d  = tctrl_q;
        tcount_d = tcount_q;
        expire   = 1'b0;
        if (wr_tctrl) begin
            tctrl_d = wdata[1:0];
            if (wdata[0]) begin
                tcount_d = tload_q;
            end
        end else if (state_q == T_RUN) begin
            if (tcount_q != '0) begin
                tcount_d = tcount_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (tctrl_q[1]) begin
                    tcount_d = tload_q;
                end else begin
                    tctrl_d[0] = 1'b0;
                end
            end
        end
        irq_d = expire || (irq_q && !(wr_tstat && wdata[0]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tload_q  <= '0;
            tcount_q <= '0;
            tctrl_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            tctrl_q  <= tctrl_d;
            irq_q    <= irq_d;
        end
    end

    always_comb irq_bit = irq_q;
`else
    always_comb irq_bit = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = mem_q[widx];
        end else if (is_mmio) begin
            case (off)
                OFF_LED:    rdata = 32'(led_q);
                OFF_CYCLE:  rdata = cycle_q;
`ifdef DM_TIMER_EN
                OFF_TLOAD:  rdata = tload_q;
                OFF_TCTRL:  rdata = {30'b0, tctrl_q};
                OFF_TCOUNT: rdata = tcount_q;
`endif
                OFF_TSTAT:  rdata = {30'b0, err_q, irq_bit};
                default:    rdata = '0;
            endcase
        end
    end

    assign led = led_q;
    assign err = err_q;
    assign irq = irq_bit;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: vector table plus hand-written
// sequences for the cycle counter, timer (when DM_TIMER_EN is defined) and reset.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A_LED    = 32'hFFFF0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF0004;
    localparam logic [31:0] A_TLOAD  = 32'hFFFF0008;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF000C;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF0010;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF0014;

`ifdef DM_TIMER_EN
    localparam logic [31:0] TL_RB = 32'd5;
`else
    localparam logic [31:0] TL_RB = 32'd0;
`endif

    dm_responder #(.DEPTH(1024), .LED_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .led      (led),
        .irq      (irq),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] rd;
        logic [15:0] led;
        logic        err;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // we, addr, wdata, chk_rd, rdata (before edge), led and err (after edge)
        vt[0]  = '{1'b1, 32'h00000014, 32'h55AA55AA, 1'b0, 32'h0,        16'h0000, 1'b0};
        vt[1]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0, 32'h0,        16'h0000, 1'b0};
        vt[2]  = '{1'b0, 32'h00000010, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0000, 1'b0};
        vt[3]  = '{1'b0, 32'h00000014, 32'h0,        1'b1, 32'h55AA55AA, 16'h0000, 1'b0};
        vt[4]  = '{1'b1, 32'h00000FFC, 32'h0BADF00D, 1'b0, 32'h0,        16'h0000, 1'b0};
        vt[5]  = '{1'b0, 32'h00000FFC, 32'h0,        1'b1, 32'h0BADF00D, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 32'h00001000, 32'h0,        1'b1, 32'h0,        16'h0000, 1'b0};
        vt[7]  = '{1'b1, 32'h00000000, 32'hCAFE0000, 1'b0, 32'h0,        16'h0000, 1'b0};
        vt[8]  = '{1'b1, A_LED,        32'h00001234, 1'b1, 32'h0,        16'h1234, 1'b0};
        vt[9]  = '{1'b0, A_LED,        32'h0,        1'b1, 32'h00001234, 16'h1234, 1'b0};
        vt[10] = '{1'b1, A_LED,        32'hFFFFABCD, 1'b1, 32'h00001234, 16'hABCD, 1'b0};
        vt[11] = '{1'b0, A_LED,        32'h0,        1'b1, 32'h0000ABCD, 16'hABCD, 1'b0};
        vt[12] = '{1'b1, 32'hFFFF0020, 32'h77777777, 1'b1, 32'h0,        16'hABCD, 1'b0};
        vt[13] = '{1'b0, 32'hFFFF0020, 32'h0,        1'b1, 32'h0,        16'hABCD, 1'b0};
        vt[14] = '{1'b1, 32'h00100000, 32'h11111111, 1'b1, 32'h0,        16'hABCD, 1'b1};
        vt[15] = '{1'b0, 32'h00100000, 32'h0,        1'b1, 32'h0,        16'hABCD, 1'b1};
        vt[16] = '{1'b0, 32'h00000000, 32'h0,        1'b1, 32'hCAFE0000, 16'hABCD, 1'b1};
        vt[17] = '{1'b0, A_TSTAT,      32'h0,        1'b1, 32'h2,        16'hABCD, 1'b1};
        vt[18] = '{1'b1, A_TSTAT,      32'h1,        1'b1, 32'h2,        16'hABCD, 1'b1};
        vt[19] = '{1'b1, A_TSTAT,      32'h2,        1'b1, 32'h2,        16'hABCD, 1'b0};
        vt[20] = '{1'b0, A_TSTAT,      32'h0,        1'b1, 32'h0,        16'hABCD, 1'b0};
        vt[21] = '{1'b1, 32'h00000003, 32'h0,        1'b1, 32'hCAFE0000, 16'hABCD, 1'b1};
        vt[22] = '{1'b1, 32'hFFFF0016, 32'h2,        1'b1, 32'h2,        16'hABCD, 1'b1};
        vt[23] = '{1'b1, A_TSTAT,      32'h2,        1'b1, 32'h2,        16'hABCD, 1'b0};
        vt[24] = '{1'b1, A_TLOAD,      32'h5,        1'b1, 32'h0,        16'hABCD, 1'b0};
        vt[25] = '{1'b0, A_TLOAD,      32'h0,        1'b1, TL_RB,        16'hABCD, 1'b0};
        vt[26] = '{1'b0, A_TCOUNT,     32'h0,        1'b1, 32'h0,        16'hABCD, 1'b0};
        vt[27] = '{1'b0, A_TCTRL,      32'h0,        1'b1, 32'h0,        16'hABCD, 1'b0};

        rst      = 1'b0;
        MemWrite = 1'b0;
        addr     = A_CYCLE;
        wdata    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset led", 32'(led), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        rd_chk("reset cycle", A_CYCLE, 32'h0);
        rd_chk("reset led rd", A_LED, 32'h0);
        rd_chk("reset tstat", A_TSTAT, 32'h0);
        rd_chk("reset tload", A_TLOAD, 32'h0);
        rd_chk("reset tctrl", A_TCTRL, 32'h0);
        rd_chk("reset tcount", A_TCOUNT, 32'h0);

        @(negedge clk);
        rst  = 1'b1;
        addr = A_CYCLE;
        repeat (100) @(posedge clk);
        #1;
        check("cycle after 100", rdata, 32'd100);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            MemWrite = vt[i].we;
            addr     = vt[i].a;
            wdata    = vt[i].d;
            #1;
            if (vt[i].chk) check($sformatf("v%0d rdata", i), rdata, vt[i].rd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d led", i), 32'(led), 32'(vt[i].led));
            check($sformatf("v%0d err", i), 32'(err), 32'(vt[i].err));
        end
        MemWrite = 1'b0;

        // Counter wrap: preload the counter flop, then let one edge advance it.
        @(negedge clk);
        addr = A_CYCLE;
        force dut.cycle_q = 32'hFFFFFFFF;
        #1;
        release dut.cycle_q;
        #1;
        check("cycle preload", rdata, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        check("cycle wrap", rdata, 32'h0);

`ifdef DM_TIMER_EN
        wr(A_TSTAT, 32'h3);
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'h1);
        rd_chk("tcount loaded", A_TCOUNT, 32'd3);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("oneshot irq k%0d", k), 32'(irq), 32'(k == 4));
        end
        rd_chk("done tctrl", A_TCTRL, 32'h0);
        rd_chk("done tcount", A_TCOUNT, 32'h0);
        rd_chk("done tstat", A_TSTAT, 32'h1);
        @(posedge clk);
        #1;
        check("irq sticky", 32'(irq), 32'h1);
        wr(A_TSTAT, 32'h1);
        check("irq w1c", 32'(irq), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("done idle irq", 32'(irq), 32'h0);

        wr(A_TCTRL, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("auto irq k%0d", k), 32'(irq), 32'(k == 4));
        end
        rd_chk("auto reload", A_TCOUNT, 32'd3);
        wr(A_TSTAT, 32'h1);
        check("auto w1c", 32'(irq), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("auto re-irq k%0d", k), 32'(irq), 32'(k == 3));
        end
        wr(A_TSTAT, 32'h1);
        check("auto w1c 2", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("auto pre-expiry", 32'(irq), 32'h0);
        wr(A_TSTAT, 32'h1);
        check("w1c vs expiry", 32'(irq), 32'h1);

        wr(A_TCTRL, 32'h0);
        wr(A_TSTAT, 32'h1);
        wr(A_TLOAD, 32'd0);
        wr(A_TCTRL, 32'h3);
        check("tload0 start", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("tload0 irq", 32'(irq), 32'h1);
        wr(A_TSTAT, 32'h1);
        check("tload0 w1c", 32'(irq), 32'h1);

        wr(A_TCTRL, 32'h0);
        wr(A_TSTAT, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("stopped irq", 32'(irq), 32'h0);

        wr(A_TLOAD, 32'd10);
        wr(A_TCTRL, 32'h1);
        repeat (2) @(posedge clk);
        wr(A_TCTRL, 32'h0);
        rd_chk("hold tcount", A_TCOUNT, 32'd8);
        repeat (2) @(posedge clk);
        #1;
        rd_chk("hold tcount 2", A_TCOUNT, 32'd8);
`else
        wr(A_TCTRL, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("no timer irq", 32'(irq), 32'h0);
        rd_chk("no timer tctrl", A_TCTRL, 32'h0);
        rd_chk("no timer tstat", A_TSTAT, 32'h0);
`endif

        wr(32'h00000020, 32'hA5A5A5A5);
`ifdef DM_TIMER_EN
        wr(A_TLOAD, 32'd0);
        wr(A_TCTRL, 32'h3);
        @(posedge clk);
        #1;
        check("pre-reset irq", 32'(irq), 32'h1);
`endif
        wr(A_LED, 32'h0000FFFF);
        wr(32'h00200000, 32'h0);
        check("pre-reset led", 32'(led), 32'hFFFF);
        check("pre-reset err", 32'(err), 32'h1);

        #2;
        MemWrite = 1'b1;
        addr     = 32'h00000020;
        wdata    = 32'h12345678;
        rst      = 1'b0;
        #1;
        check("async rst led", 32'(led), 32'h0);
        check("async rst err", 32'(err), 32'h0);
        check("async rst irq", 32'(irq), 32'h0);
        addr = A_CYCLE;
        #1;
        check("async rst cycle", rdata, 32'h0);
        addr = 32'h00000020;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst      = 1'b1;
        MemWrite = 1'b0;
        #1;
        check("store in reset dropped", rdata, 32'hA5A5A5A5);
        addr = A_CYCLE;
        repeat (5) @(posedge clk);
        #1;
        check("cycle after re-reset", rdata, 32'd5);
        rd_chk("post-reset tctrl", A_TCTRL, 32'h0);
        rd_chk("post-reset tcount", A_TCOUNT, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("post-reset irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
